// File: rtl/wb_spram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_spram_ctrl : Wishbone B4 pipelined slave driving a single-port RAM,
//                 fixed 2-cycle latency, one request per cycle.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module wb_spram_ctrl #(
  parameter int          MEMSIZE   = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         AWIDTH    = $clog2(MEMSIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [31:0]       wb_adr,
  input  logic [3:0]        wb_sel,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack,
  output logic              wb_err,
  output logic              wb_stall,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [AWIDTH-1:0] ram_address,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q
);

  // One past the last legal byte address; 33 bits so the window cannot wrap.
  localparam logic [32:0] c_LIMIT = {1'b0, BASE_ADDR} + (33'(MEMSIZE) << 2);

  logic              r_s1_vld;
  logic              r_s1_we;
  logic              r_s1_ill;
  logic [3:0]        r_s1_sel;
  logic [31:0]       r_s1_dat;
  logic [AWIDTH-1:0] r_s1_addr;
  logic              r_s2_vld;
  logic              r_s2_we;
  logic              r_s2_ill;

  logic w_accept;
  logic w_illegal;
  logic w_s1_go;

  assign w_accept  = wb_cyc & wb_stb & ~rst;
  assign w_illegal = (wb_adr[1:0] != 2'b00)
                   | ({1'b0, wb_adr} < {1'b0, BASE_ADDR})
                   | ({1'b0, wb_adr} >= c_LIMIT);

  // A dropped cycle or a reset in flight suppresses the RAM access immediately.
  assign w_s1_go     = r_s1_vld & wb_cyc & ~rst & ~r_s1_ill;
  assign ram_rden    = w_s1_go & ~r_s1_we;
  assign ram_wren    = w_s1_go & r_s1_we & (|r_s1_sel);
  assign ram_address = r_s1_addr;
  assign ram_byteena = r_s1_sel;
  assign ram_data    = r_s1_dat;

  assign wb_stall = rst;
  assign wb_ack   = r_s2_vld & ~rst & ~r_s2_ill;
  assign wb_err   = r_s2_vld & ~rst & r_s2_ill;
  assign wb_dat_o = (wb_ack & ~r_s2_we) ? ram_q : 32'h0;

  always_ff @(posedge clk) begin
    if (rst || !wb_cyc) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= wb_stb;
      r_s2_vld <= r_s1_vld;
    end
    // Request fields load only on acceptance so ram_address holds when idle.
    if (w_accept) begin
      r_s1_we   <= wb_we;
      r_s1_ill  <= w_illegal;
      r_s1_sel  <= wb_sel;
      r_s1_dat  <= wb_dat_i;
      r_s1_addr <= AWIDTH'((wb_adr - BASE_ADDR) >> 2);
    end
    r_s2_we  <= r_s1_we;
    r_s2_ill <= r_s1_ill;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_spram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_spram_ctrl : directed + randomized bench with a request-queue model.
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_wb_spram_ctrl;
  localparam int          MEMSIZE = 64;
  localparam int          AW      = 6;
  localparam logic [31:0] BASE    = 32'h1000_0000;

  logic          clk;
  logic          rst;
  logic          wb_cyc, wb_stb, wb_we;
  logic [31:0]   wb_adr;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_dat_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack, wb_err, wb_stall;
  logic          ram_rden, ram_wren;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_byteena;
  logic [31:0]   ram_data;
  logic [31:0]   ram_q;

  wb_spram_ctrl #(.MEMSIZE(MEMSIZE), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
    .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_address(ram_address),
    .ram_byteena(ram_byteena), .ram_data(ram_data), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM attached to the controller.
  logic [31:0] bench_ram [MEMSIZE];
  initial ram_q = 32'h0;
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) bench_ram[ram_address][b*8 +: 8] <= ram_data[b*8 +: 8];
    if (ram_rden) ram_q <= bench_ram[ram_address];
  end

  // Reference model: expected memory image plus a queue of accepted requests.
  typedef struct {
    int        acyc;
    bit        we;
    bit [3:0]  sel;
    bit [31:0] dat;
    bit        legal;
    int        word;
    bit [31:0] rdata;
  } req_t;

  req_t        q[$];
  logic [31:0] mem_model [MEMSIZE];
  int          cyc_n = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_ack = 0, n_err = 0, n_rden = 0, n_wren = 0;
  logic [31:0] last_ack_dat = 32'h0;
  logic [AW-1:0] last_wren_addr = '0;
  logic [AW-1:0] exp_addr = '0;
  bit          addr_known = 1'b0;

  function automatic bit is_legal(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a[1:0] == 2'b00) && (la >= longint'(BASE)) &&
           (la < longint'(BASE) + 4 * MEMSIZE);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    bit        e_rden, e_wren, e_ack, e_err, live;
    bit [3:0]  e_be;
    bit [31:0] e_data, e_dat;
    req_t      r;
    e_rden = 0; e_wren = 0; e_ack = 0; e_err = 0;
    e_be = 4'h0; e_data = 32'h0; e_dat = 32'h0;
    live = wb_cyc && !rst;
    foreach (q[i]) begin
      if (q[i].acyc == cyc_n - 1) begin
        if (live && q[i].legal) begin
          if (q[i].we) begin
            if (q[i].sel != 4'h0) begin
              e_wren = 1; e_be = q[i].sel; e_data = q[i].dat;
              for (int b = 0; b < 4; b++)
                if (q[i].sel[b]) mem_model[q[i].word][b*8 +: 8] = q[i].dat[b*8 +: 8];
            end
          end else begin
            e_rden = 1;
            q[i].rdata = mem_model[q[i].word];
          end
        end
      end else if (q[i].acyc == cyc_n - 2 && !rst) begin
        e_ack = q[i].legal;
        e_err = !q[i].legal;
        e_dat = (q[i].legal && !q[i].we) ? q[i].rdata : 32'h0;
      end
    end

    chk("stall", 32'(wb_stall), 32'(rst));
    chk("ack", 32'(wb_ack), 32'(e_ack));
    chk("err", 32'(wb_err), 32'(e_err));
    chk("dat_o", wb_dat_o, e_dat);
    chk("rden", 32'(ram_rden), 32'(e_rden));
    chk("wren", 32'(ram_wren), 32'(e_wren));
    if (addr_known) chk("ram_address", 32'(ram_address), 32'(exp_addr));
    if (e_wren) begin
      chk("byteena", 32'(ram_byteena), 32'(e_be));
      chk("ram_data", ram_data, e_data);
    end

    if (wb_ack) begin n_ack++; last_ack_dat = wb_dat_o; end
    if (wb_err) n_err++;
    if (ram_rden) n_rden++;
    if (ram_wren) begin n_wren++; last_wren_addr = ram_address; end

    while (q.size() > 0 && q[0].acyc <= cyc_n - 2) void'(q.pop_front());
    if (!wb_cyc || rst) q.delete();
    if (wb_cyc && wb_stb && !rst) begin
      r.acyc  = cyc_n;
      r.we    = wb_we;
      r.sel   = wb_sel;
      r.dat   = wb_dat_i;
      r.legal = is_legal(wb_adr);
      r.word  = int'(((wb_adr - BASE) >> 2) & 32'(MEMSIZE - 1));
      r.rdata = 32'h0;
      exp_addr   = AW'(r.word);
      addr_known = 1'b1;
      q.push_back(r);
    end
    cyc_n++;
  end

  task automatic drive(input bit r, input bit c, input bit s, input bit w,
                       input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
    rst = r; wb_cyc = c; wb_stb = s; wb_we = w;
    wb_adr = a; wb_sel = sl; wb_dat_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    int a0, e0, r0;
    logic [31:0] adr;
    for (int i = 0; i < MEMSIZE; i++) begin
      bench_ram[i] = $urandom;
      mem_model[i] = bench_ram[i];
    end
    drive(1, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    drive(1, 1, 1, 0, BASE, 4'hF, 32'h0);
    chk("reset_stall", 32'(wb_stall), 32'd1);
    chk("reset_ack", 32'(wb_ack), 32'd0);
    chk("reset_rden", 32'(ram_rden), 32'd0);

    // Write then read back at word 4.
    drive(0, 1, 1, 1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    drive(0, 1, 1, 0, BASE + 32'h10, 4'hF, 32'h0);
    idle(3);
    chk("wr_rd_wren_addr", 32'(last_wren_addr), 32'd4);
    chk("wr_rd_data", last_ack_dat, 32'hDEAD_BEEF);

    // Partial byte write merges into existing word.
    drive(0, 1, 1, 1, BASE + 32'h14, 4'hF, 32'h1122_3344);
    drive(0, 1, 1, 1, BASE + 32'h14, 4'b0010, 32'h0000_AB00);
    drive(0, 1, 1, 0, BASE + 32'h14, 4'hF, 32'h0);
    idle(3);
    chk("byte_merge", last_ack_dat, 32'h1122_AB44);

    // Four back-to-back reads.
    a0 = n_ack;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, BASE + 32'h10 + 32'(4 * i), 4'hF, 32'h0);
      chk("burst_stall", 32'(wb_stall), 32'd0);
    end
    idle(3);
    chk("burst_acks", 32'(n_ack - a0), 32'd4);

    // Out-of-window and misaligned accesses.
    a0 = n_ack; e0 = n_err; r0 = n_rden + n_wren;
    drive(0, 1, 1, 0, BASE + 32'(4 * MEMSIZE), 4'hF, 32'h0);
    drive(0, 1, 1, 1, BASE + 32'h2, 4'hF, 32'h1234_5678);
    idle(3);
    chk("illegal_errs", 32'(n_err - e0), 32'd2);
    chk("illegal_acks", 32'(n_ack - a0), 32'd0);
    chk("illegal_ram", 32'(n_rden + n_wren - r0), 32'd0);

    // Cycle dropped right after acceptance.
    a0 = n_ack; e0 = n_err; r0 = n_rden;
    drive(0, 1, 1, 0, BASE + 32'h8, 4'hF, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    idle(3);
    chk("drop_rden", 32'(n_rden - r0), 32'd0);
    chk("drop_resp", 32'(n_ack - a0 + n_err - e0), 32'd0);

    // Reset with two requests in flight.
    a0 = n_ack; e0 = n_err;
    drive(0, 1, 1, 0, BASE + 32'h10, 4'hF, 32'h0);
    drive(0, 1, 1, 0, BASE + 32'h14, 4'hF, 32'h0);
    drive(1, 1, 1, 0, BASE + 32'h18, 4'hF, 32'h0);
    chk("rst_stall0", 32'(wb_stall), 32'd1);
    drive(1, 1, 1, 0, BASE + 32'h18, 4'hF, 32'h0);
    chk("rst_stall1", 32'(wb_stall), 32'd1);
    drive(0, 1, 1, 0, BASE + 32'h10, 4'hF, 32'h0);
    idle(3);
    chk("rst_acks", 32'(n_ack - a0), 32'd1);
    chk("rst_errs", 32'(n_err - e0), 32'd0);
    chk("rst_after_data", last_ack_dat, 32'hDEAD_BEEF);

    // Randomized traffic, concentrated on a small window for hazards.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) != 0) adr = BASE + 32'(4 * $urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 3))
          0: adr = BASE - 32'h4;
          1: adr = BASE + 32'(4 * MEMSIZE) + 32'(4 * $urandom_range(0, 3));
          2: adr = BASE + 32'(4 * $urandom_range(0, MEMSIZE - 1)) + 32'($urandom_range(1, 3));
          default: adr = $urandom;
        endcase
      end
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            adr, 4'($urandom), $urandom);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
